// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multi-cycle cpu_core: opcodes, flag bit positions,
// FSM state encoding and opcode classification helpers.
package cpu_core_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_ADC = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_NOT = 8'h06;
    localparam logic [7:0] OP_SHL = 8'h07;
    localparam logic [7:0] OP_SHR = 8'h08;
    localparam logic [7:0] OP_LDI = 8'h09;
    localparam logic [7:0] OP_MOV = 8'h0A;
    localparam logic [7:0] OP_CMP = 8'h0B;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_P = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Anything above CMP is treated as a NOP by the core.
    function automatic logic op_known(input logic [7:0] op);
        return op <= OP_CMP;
    endfunction

    function automatic logic op_writes(input logic [7:0] op);
        return (op < OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core: computes the result and {P,V,N,Z,C} flags
// for one opcode, with arithmetic carried out at WIDTH+1 bits.
module cpu_alu
    import cpu_core_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    logic [WIDTH:0] ext;
    logic           c_bit;
    logic           v_bit;

    always_comb begin
        ext   = '0;
        c_bit = 1'b0;
        v_bit = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
                c_bit = ext[WIDTH];
                v_bit = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            // The top bit of the extended difference is the borrow.
            OP_SUB, OP_CMP: begin
                ext   = {1'b0, a} - {1'b0, b};
                c_bit = ext[WIDTH];
                v_bit = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: ext = {1'b0, a & b};
            OP_OR:  ext = {1'b0, a | b};
            OP_XOR: ext = {1'b0, a ^ b};
            OP_NOT: ext = {1'b0, ~a};
            OP_SHL: begin
                ext   = {a, 1'b0};
                c_bit = a[WIDTH-1];
            end
            OP_SHR: begin
                ext   = {2'b00, a[WIDTH-1:1]};
                c_bit = a[0];
            end
            OP_LDI: ext = {1'b0, imm};
            OP_MOV: ext = {1'b0, a};
            default: ext = '0;
        endcase
        result         = ext[WIDTH-1:0];
        flags          = '0;
        flags[FLAG_C]  = c_bit;
        flags[FLAG_Z]  = (ext[WIDTH-1:0] == '0);
        flags[FLAG_N]  = ext[WIDTH-1];
        flags[FLAG_V]  = v_bit;
        flags[FLAG_P]  = ~^ext[WIDTH-1:0];
    end

endmodule

// File: rtl/seven_seg_hex.sv
// Active-low hex seven-segment decoder, seg[0]=a .. seg[6]=g.
// Only compiled when CPU_CORE_SEG_EN is defined, since nothing else uses it.
`ifdef CPU_CORE_SEG_EN
module seven_seg_hex (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] on_q;

    always_comb begin
        case (hex)
            4'h0: on_q = 7'h3F;
            4'h1: on_q = 7'h06;
            4'h2: on_q = 7'h5B;
            4'h3: on_q = 7'h4F;
            4'h4: on_q = 7'h66;
            4'h5: on_q = 7'h6D;
            4'h6: on_q = 7'h7D;
            4'h7: on_q = 7'h07;
            4'h8: on_q = 7'h7F;
            4'h9: on_q = 7'h6F;
            4'hA: on_q = 7'h77;
            4'hB: on_q = 7'h7C;
            4'hC: on_q = 7'h39;
            4'hD: on_q = 7'h5E;
            4'hE: on_q = 7'h79;
            default: on_q = 7'h71;
        endcase
        seg = ~on_q;
    end

endmodule
`endif

// File: rtl/cpu_core.sv
// Four-cycle multi-cycle core (IDLE->READ->EXEC->WB) with register file and ALU.
// Define CPU_CORE_SEG_EN to drive seg_out from per-nibble hex decoders on result.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [7:0]             opcode,
    input  logic [RW-1:0]          rd,
    input  logic [RW-1:0]          rs1,
    input  logic [RW-1:0]          rs2,
    input  logic [WIDTH-1:0]       imm,
    input  logic                   cin,
    output logic [WIDTH-1:0]       result,
    output logic                   result_valid,
    output logic [4:0]             flags,
    output logic [7*(WIDTH/4)-1:0] seg_out
);

    state_t           state_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic [7:0]       op_q;
    logic [RW-1:0]    rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] imm_q;
    logic             cin_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] rs1_val, rs2_val;
    logic [WIDTH-1:0] result_d;
    logic [4:0]       flags_d;

    // Register 0 is hardwired to zero on the read side as well.
    assign rs1_val = (rs1_q == '0) ? '0 : regs_q[rs1_q];
    assign rs2_val = (rs2_q == '0) ? '0 : regs_q[rs2_q];

    cpu_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .cin    (cin_q),
        .result (result_d),
        .flags  (flags_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid && ready_q) begin
                        op_q    <= opcode;
                        rd_q    <= rd;
                        rs1_q   <= rs1;
                        rs2_q   <= rs2;
                        imm_q   <= imm;
                        cin_q   <= cin;
                        ready_q <= 1'b0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    a_q     <= rs1_val;
                    b_q     <= rs2_val;
                    state_q <= ST_EXEC;
                end
                // Results land at the EXEC->WB edge so WB presents them with result_valid.
                ST_EXEC: begin
                    valid_q <= 1'b1;
                    if (op_known(op_q)) begin
                        result_q <= result_d;
                        flags_q  <= flags_d;
                        if (op_writes(op_q) && (rd_q != '0)) regs_q[rd_q] <= result_d;
                    end
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready  = ready_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign flags        = flags_q;

`ifdef CPU_CORE_SEG_EN
    for (genvar k = 0; k < WIDTH/4; k++) begin : g_seg
        seven_seg_hex u_seg (
            .hex (result_q[4*k +: 4]),
            .seg (seg_out[7*k +: 7])
        );
    end
`else
    assign seg_out = '1;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core (WIDTH=16, NREGS=8).
module tb_cpu_core;
  import cpu_core_pkg::*;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic        cin;
  logic [15:0] result;
  logic        result_valid;
  logic [4:0]  flags;
  logic [27:0] seg_out;

  int passed;
  int total;

`ifdef CPU_CORE_SEG_EN
  localparam logic [27:0] SEG_RST  = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEG_8000 = {7'h00, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEG_9AF5 = {7'h10, 7'h08, 7'h0E, 7'h12};
`else
  localparam logic [27:0] SEG_RST  = 28'hFFFFFFF;
  localparam logic [27:0] SEG_8000 = 28'hFFFFFFF;
  localparam logic [27:0] SEG_9AF5 = 28'hFFFFFFF;
`endif

  cpu_core #(.WIDTH(16), .NREGS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .cin          (cin),
    .result       (result),
    .result_valid (result_valid),
    .flags        (flags),
    .seg_out      (seg_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // driver: offer one instruction at a negedge, return outputs seen in the result_valid cycle
  task automatic run_instr(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [15:0] im, input logic ci,
                           output logic [15:0] res, output logic [4:0] flg,
                           output logic [27:0] seg, output int lat);
    int n;
    res = 'x; flg = 'x; seg = 'x; lat = -1;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; cin = ci;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      total++;
      $display("FAIL accept_timeout op=%h ready=%b want 1", op, instr_ready);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (result_valid) break;
    end
    if (!result_valid) begin
      total++;
      $display("FAIL result_timeout op=%h result_valid=%b want 1", op, result_valid);
      return;
    end
    lat = n;
    res = result;
    flg = flags;
    seg = seg_out;
  endtask

  task automatic test_reset();
    total++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", instr_ready); else passed++;
    total++; if (result_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", result_valid); else passed++;
    total++; if (result !== 16'h0000) $display("FAIL rst_result got %h want 0000", result); else passed++;
    total++; if (flags !== 5'b00000) $display("FAIL rst_flags got %b want 00000", flags); else passed++;
    total++; if (seg_out !== SEG_RST) $display("FAIL rst_seg got %h want %h", seg_out, SEG_RST); else passed++;
  endtask

  task automatic test_add();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0001, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h0001) $display("FAIL ldi_r1 got %h want 0001", r); else passed++;
    total++; if (lat !== 3) $display("FAIL ldi_latency got %0d want 3", lat); else passed++;
    run_instr(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h7FFF, 1'b0, r, f, s, lat);
    total++; if (f !== 5'b00000) $display("FAIL ldi_r2_flags got %b want 00000", f); else passed++;
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h8000) $display("FAIL add_result got %h want 8000", r); else passed++;
    total++; if (f !== 5'b01100) $display("FAIL add_flags got %b want 01100", f); else passed++;
    total++; if (s !== SEG_8000) $display("FAIL add_seg got %h want %h", s, SEG_8000); else passed++;
    total++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else passed++;
  endtask

  task automatic test_adc();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_LDI, 3'd4, 3'd0, 3'd0, 16'hFFFF, 1'b0, r, f, s, lat);
    total++; if (f !== 5'b10100) $display("FAIL ldi_ffff_flags got %b want 10100", f); else passed++;
    run_instr(OP_ADC, 3'd5, 3'd4, 3'd0, 16'h0000, 1'b1, r, f, s, lat);
    total++; if (r !== 16'h0000) $display("FAIL adc_result got %h want 0000", r); else passed++;
    total++; if (f !== 5'b10011) $display("FAIL adc_flags got %b want 10011", f); else passed++;
  endtask

  task automatic test_sub_cmp();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_SUB, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h8002) $display("FAIL sub_result got %h want 8002", r); else passed++;
    total++; if (f !== 5'b10101) $display("FAIL sub_flags got %b want 10101", f); else passed++;
    run_instr(OP_CMP, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (f !== 5'b10010) $display("FAIL cmp_flags got %b want 10010", f); else passed++;
    run_instr(OP_MOV, 3'd0, 3'd1, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h0001) $display("FAIL cmp_r1_kept got %h want 0001", r); else passed++;
    run_instr(OP_MOV, 3'd0, 3'd6, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h8002) $display("FAIL r6_readback got %h want 8002", r); else passed++;
  endtask

  task automatic test_logic_shift();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_AND, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h0001) $display("FAIL and_result got %h want 0001", r); else passed++;
    run_instr(OP_OR, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h7FFF) $display("FAIL or_result got %h want 7FFF", r); else passed++;
    run_instr(OP_NOT, 3'd0, 3'd1, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'hFFFE, 5'b00100}) $display("FAIL not_res_flags got %h/%b want FFFE/00100", r, f); else passed++;
    run_instr(OP_SHL, 3'd0, 3'd2, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'hFFFE, 5'b00100}) $display("FAIL shl_res_flags got %h/%b want FFFE/00100", r, f); else passed++;
    run_instr(OP_SHR, 3'd0, 3'd1, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h0000, 5'b10011}) $display("FAIL shr_res_flags got %h/%b want 0000/10011", r, f); else passed++;
    run_instr(OP_XOR, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h7FFE, 5'b10000}) $display("FAIL xor_res_flags got %h/%b want 7FFE/10000", r, f); else passed++;
    run_instr(8'h3C, 3'd1, 3'd2, 3'd2, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h7FFE, 5'b10000}) $display("FAIL nop_res_flags got %h/%b want 7FFE/10000", r, f); else passed++;
    total++; if (lat !== 3) $display("FAIL nop_latency got %0d want 3", lat); else passed++;
    run_instr(OP_MOV, 3'd0, 3'd1, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h0001) $display("FAIL nop_r1_kept got %h want 0001", r); else passed++;
  endtask

  task automatic test_r0_seg();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_LDI, 3'd7, 3'd0, 3'd0, 16'h9AF5, 1'b0, r, f, s, lat);
    total++; if (s !== SEG_9AF5) $display("FAIL seg_9af5 got %h want %h", s, SEG_9AF5); else passed++;
    run_instr(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h1234, 5'b00000}) $display("FAIL ldi_r0_res_flags got %h/%b want 1234/00000", r, f); else passed++;
    run_instr(OP_MOV, 3'd7, 3'd0, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h0000, 5'b10010}) $display("FAIL mov_r7_r0 got %h/%b want 0000/10010", r, f); else passed++;
  endtask

  task automatic test_hazard();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h0005, 1'b0, r, f, s, lat);
    run_instr(OP_ADD, 3'd3, 3'd3, 3'd3, 16'h0000, 1'b0, r, f, s, lat);
    total++; if ({r, f} !== {16'h000A, 5'b10000}) $display("FAIL hazard_add got %h/%b want 000A/10000", r, f); else passed++;
    run_instr(OP_MOV, 3'd0, 3'd3, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h000A) $display("FAIL hazard_r3 got %h want 000A", r); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    opcode = OP_MOV; rd = 3'd0; rs1 = 3'd1; rs2 = 3'd0; imm = 16'h0000; cin = 1'b0;
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (instr_ready !== ((i % 4) == 0)) $display("FAIL b2b_ready cyc=%0d got %b want %b", i, instr_ready, (i % 4) == 0);
      else passed++;
      total++;
      if (result_valid !== ((i % 4) == 3)) $display("FAIL b2b_valid cyc=%0d got %b want %b", i, result_valid, (i % 4) == 3);
      else passed++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] r; logic [4:0] f; logic [27:0] s; int lat;
    run_instr(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h0042, 1'b0, r, f, s, lat);
    opcode = OP_ADD; rd = 3'd3; rs1 = 3'd1; rs2 = 3'd2; imm = 16'h0000; cin = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    total++; if (instr_ready !== 1'b1) $display("FAIL abort_pre_ready got %b want 1", instr_ready); else passed++;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (instr_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", instr_ready); else passed++;
    total++; if (flags !== 5'b00000) $display("FAIL abort_flags got %b want 00000", flags); else passed++;
    total++; if (result !== 16'h0000) $display("FAIL abort_result got %h want 0000", result); else passed++;
    @(negedge clk);
    total++; if (result_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", result_valid); else passed++;
    run_instr(OP_MOV, 3'd0, 3'd3, 3'd0, 16'h0000, 1'b0, r, f, s, lat);
    total++; if (r !== 16'h0000) $display("FAIL abort_r3 got %h want 0000", r); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_adc();
    test_sub_cmp();
    test_logic_shift();
    test_r0_seg();
    test_hazard();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath and register width; legal values are multiples of 4, from 8 to 32.
REQ-002 SHALL have parameter NREGS, default 8, register file depth; legal values are powers of 2, from 4 to 32.
REQ-003 SHALL define RW = log2(NREGS) as a derived localparam.
REQ-004 SHALL have clock and reset ports clk and rst: one clock, reset asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  core can accept an instruction
- opcode  in  8  operation code
- rd  in  RW  destination register
- rs1  in  RW  source A
- rs2  in  RW  source B
- imm  in  WIDTH  immediate value for LDI
- cin  in  1  carry-in for ADC, sampled on accept
- result  out  WIDTH  last ALU result
- result_valid  out  1  one-cycle completion pulse
- flags  out  5  {P,V,N,Z,C}, with C in bit 0
- seg_out  out  7*(WIDTH/4)  active-low seven-segment digits; digit k shows result[4k+3:4k]

Function
REQ-006 SHALL accept an instruction on a rising edge where instr_valid and instr_ready are both high, capturing opcode, rd, rs1, rs2, imm and cin.
REQ-007 SHALL use the FSM IDLE -> READ -> EXEC -> WB -> IDLE; instr_ready SHALL be high only in IDLE.
REQ-008 READ SHALL latch regs[rs1] and regs[rs2] into operand registers.
REQ-009 EXEC SHALL compute the ALU result and next flags.
REQ-010 WB SHALL register result and flags, write rd, and hold result_valid high for exactly that cycle.
REQ-011 result_valid SHALL be high in the 3rd cycle after the accept edge; the earliest next accept is one cycle later, giving one instruction per 4 cycles.
REQ-012 instr_valid while not ready SHALL be ignored; the offering side must hold its fields until accepted.
REQ-013 Opcodes SHALL be:
- 00 ADD, 01 ADC, 02 SUB (A-B), 03 AND, 04 OR, 05 XOR, 06 NOT (of A)
- 07 SHL by 1, 08 SHR logical by 1, 09 LDI (imm), 0A MOV (A), 0B CMP (A-B, no write)
REQ-014 Arithmetic SHALL be computed at WIDTH+1 bits; C is the carry-out for ADD/ADC and the borrow for SUB/CMP.
REQ-015 V SHALL be the signed overflow for ADD/ADC/SUB/CMP.
REQ-016 For SHL/SHR, C SHALL be the bit shifted out; all other ops SHALL give C=0 and V=0.
REQ-017 Z SHALL be 1 when the result is 0, N SHALL equal the result MSB, and P SHALL be 1 when the result has an even number of ones.
REQ-018 Register 0 SHALL read as 0; writes to it SHALL be discarded, though result and flags still update.
REQ-019 An unknown opcode SHALL act as a NOP: no register write, result and flags unchanged, result_valid still pulses.
REQ-020 When rd equals rs1 or rs2 of the next instruction, that instruction SHALL see the written value, since writeback completes before the next READ.

Reset
REQ-021 Asserting rst SHALL immediately force: FSM to IDLE, all registers to 0, result=0, flags=0, result_valid=0, instr_ready=1 after release.
REQ-022 Reset in any state SHALL abort the in-flight instruction with no register write.

Configuration
REQ-023 With macro CPU_CORE_SEG_EN defined, the core SHALL instantiate WIDTH/4 seven_seg_hex decoders on result.
REQ-024 Without CPU_CORE_SEG_EN, the core SHALL drive seg_out to all-ones (blank), have no decoder instances, and keep all other behaviour identical.

Structure
REQ-025 Package cpu_core_pkg SHALL hold the opcode constants, the flag bit indices (FLAG_C=0 .. FLAG_P=4) and the FSM state typedef.
REQ-026 The combinational ALU SHALL be sub-module cpu_alu, parametrised by WIDTH, with outputs result and 5-bit flags.
REQ-027 The register file and FSM SHALL reside in cpu_core.

Verification (WIDTH=16, NREGS=8, CPU_CORE_SEG_EN defined)
REQ-028 LDI R1=0001 and LDI R2=7FFF, then ADD R3,R1,R2 -> result 8000, flags V=1, N=1, Z=0, C=0, P=0; seg digits show 8,0,0,0.
REQ-029 LDI R4=FFFF, then ADC R5,R4,R0 with cin=1 -> result 0000, C=1, Z=1, P=1, V=0.
REQ-030 SUB R6,R1,R2 gives result 8002 with C=1 and N=1; CMP R1,R1 gives Z=1, with R-registers unchanged on readback via MOV.
REQ-031 LDI R0=1234, then MOV R7,R0 -> R7 reads 0000.
REQ-032 Hold instr_valid high continuously -> accepts exactly every 4 cycles, and result_valid is a one-cycle pulse 3 cycles after each accept.
REQ-033 Assert rst during EXEC of ADD R3 -> no write; after release R3=0000, flags=0 and instr_ready=1.
